// File: rtl/enemy_pkg.sv
// Shared types and default parameters for the enemy spawner slice.
// Holds the FSM state enum, location defaults and the location type.
package enemy_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_COOLDOWN
  } state_t;

  localparam int DEF_NUM_TYPES = 4;
  localparam int DEF_LOC_W     = 11;
  localparam int DEF_LOC_MIN   = 64;
  localparam int DEF_LOC_STEP  = 32;

  typedef logic [DEF_LOC_W-1:0] loc_t;

endpackage

// File: rtl/lowest_free_finder.sv
// Priority encoder: picks the lowest set bit of free_i.
// Ports: free_i (N) -> found_o, idx_o (W), onehot_o (N).
module lowest_free_finder #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] free_i,
  output logic         found_o,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] onehot_o
);

  assign found_o  = |free_i;
  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = free_i & (~free_i + N'(1));

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/enemy_spawner.sv
// Slot-managed enemy spawner: allocates the lowest free slot on a
// generateNew rise, rate-limited by a cooldown; kill strobes free slots.
// In: clk, resetN, generateNew, randomType, randomLocation, enemyKilled.
// Out: generateInstance, newSlot(+OneHot), newType, newLocation,
//      aliveMask, aliveCount, full, requestDropped.
module enemy_spawner
  import enemy_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int RAND_W    = 4,
  parameter int NUM_TYPES = DEF_NUM_TYPES,
  parameter int LOC_W     = DEF_LOC_W,
  parameter int LOC_MIN   = DEF_LOC_MIN,
  parameter int LOC_STEP  = DEF_LOC_STEP,
  parameter int COOLDOWN  = 16,
  parameter int SLOT_W    = $clog2(NUM_SLOTS),
  parameter int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 generateNew,
  input  logic [RAND_W-1:0]    randomType,
  input  logic [RAND_W-1:0]    randomLocation,
  input  logic [NUM_SLOTS-1:0] enemyKilled,
  output logic                 generateInstance,
  output logic [SLOT_W-1:0]    newSlot,
  output logic [NUM_SLOTS-1:0] newSlotOneHot,
  output logic [RAND_W-1:0]    newType,
  output logic [LOC_W-1:0]     newLocation,
  output logic [NUM_SLOTS-1:0] aliveMask,
  output logic [CNT_W-1:0]     aliveCount,
  output logic                 full,
  output logic                 requestDropped
);

  localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  state_t               state_q, state_d;
  logic [CD_W-1:0]      cnt_q, cnt_d;
  logic                 gen_prev_q;
  logic                 pending_q, pending_d;
  logic [NUM_SLOTS-1:0] alive_q, alive_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 gi_q, gi_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [NUM_SLOTS-1:0] oh_q, oh_d;
  logic [RAND_W-1:0]    type_q, type_d;
  logic [LOC_W-1:0]     loc_q, loc_d;
  logic                 drop_q, drop_d;

  logic                 found;
  logic [SLOT_W-1:0]    free_idx;
  logic [NUM_SLOTS-1:0] free_oh;
  logic                 rise;
  logic                 spawn;
  logic [31:0]          type_w;
  logic [31:0]          loc_w;

  // Selection works on the pre-kill mask.
  lowest_free_finder #(
    .N (NUM_SLOTS),
    .W (SLOT_W)
  ) u_finder (
    .free_i   (~alive_q),
    .found_o  (found),
    .idx_o    (free_idx),
    .onehot_o (free_oh)
  );

  assign rise   = generateNew & ~gen_prev_q;
  assign spawn  = (state_q == ST_IDLE) & (rise | pending_q)
                & ~full_q & found;
  assign type_w = 32'(randomType) % 32'(NUM_TYPES);
  assign loc_w  = 32'(LOC_MIN)
                + 32'(randomLocation) * 32'(LOC_STEP);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    slot_d    = slot_q;
    type_d    = type_q;
    loc_d     = loc_q;
    gi_d      = 1'b0;
    oh_d      = '0;
    drop_d    = 1'b0;
    alive_d   = alive_q & ~enemyKilled;
    if (spawn) begin
      gi_d      = 1'b1;
      oh_d      = free_oh;
      slot_d    = free_idx;
      type_d    = RAND_W'(type_w);
      loc_d     = LOC_W'(loc_w);
      alive_d   = alive_d | free_oh;
      pending_d = 1'b0;
      if (COOLDOWN != 0) begin
        state_d = ST_COOLDOWN;
        cnt_d   = CD_W'(COOLDOWN - 1);
      end
    end else begin
      if (rise) pending_d = 1'b1;
      drop_d = rise & pending_q;
      if (state_q == ST_COOLDOWN) begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CD_W'(1);
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      count_d = count_d + CNT_W'(alive_d[i]);
    end
    full_d = &alive_d;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gen_prev_q <= 1'b0;
      pending_q  <= 1'b0;
      alive_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      gi_q       <= 1'b0;
      slot_q     <= '0;
      oh_q       <= '0;
      type_q     <= '0;
      loc_q      <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gen_prev_q <= generateNew;
      pending_q  <= pending_d;
      alive_q    <= alive_d;
      count_q    <= count_d;
      full_q     <= full_d;
      gi_q       <= gi_d;
      slot_q     <= slot_d;
      oh_q       <= oh_d;
      type_q     <= type_d;
      loc_q      <= loc_d;
      drop_q     <= drop_d;
    end
  end

  assign generateInstance = gi_q;
  assign newSlot          = slot_q;
  assign newSlotOneHot    = oh_q;
  assign newType          = type_q;
  assign newLocation      = loc_q;
  assign aliveMask        = alive_q;
  assign aliveCount       = count_q;
  assign full             = full_q;
  assign requestDropped   = drop_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// Bench for enemy_spawner: expected spawns queued at stimulus time,
// popped and compared whenever generateInstance pulses.
module tb_enemy_spawner;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       generateNew = 1'b0;
  logic [3:0] randomType = '0;
  logic [3:0] randomLocation = '0;
  logic [7:0] enemyKilled = '0;
  logic       generateInstance;
  logic [2:0] newSlot;
  logic [7:0] newSlotOneHot;
  logic [3:0] newType;
  logic [10:0] newLocation;
  logic [7:0] aliveMask;
  logic [3:0] aliveCount;
  logic       full;
  logic       requestDropped;

  typedef struct {
    logic [2:0]  slot;
    logic [3:0]  typ;
    logic [10:0] loc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  enemy_spawner dut (
    .clk              (clk),
    .resetN           (resetN),
    .generateNew      (generateNew),
    .randomType       (randomType),
    .randomLocation   (randomLocation),
    .enemyKilled      (enemyKilled),
    .generateInstance (generateInstance),
    .newSlot          (newSlot),
    .newSlotOneHot    (newSlotOneHot),
    .newType          (newType),
    .newLocation      (newLocation),
    .aliveMask        (aliveMask),
    .aliveCount       (aliveCount),
    .full             (full),
    .requestDropped   (requestDropped)
  );

  // Scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] oh;
    if (resetN) begin
      n_cmp++;
      if (generateInstance) begin
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL spawn_unexpected: got slot %0d, required none",
                   newSlot);
        end else begin
          e  = q.pop_front();
          oh = 8'h01 << e.slot;
          if ({newSlot, newSlotOneHot, newType, newLocation}
              !== {e.slot, oh, e.typ, e.loc}) begin
            n_bad++;
            $display("FAIL spawn_data: got s=%0d oh=%h t=%0d l=%0d, required s=%0d oh=%h t=%0d l=%0d",
                     newSlot, newSlotOneHot, newType, newLocation,
                     e.slot, oh, e.typ, e.loc);
          end
        end
      end else if (newSlotOneHot !== 8'h00) begin
        n_bad++;
        $display("FAIL onehot_idle: got %h, required 00", newSlotOneHot);
      end
    end
  end

  task automatic push_exp(input int slot);
    exp_t e;
    e.slot = slot[2:0];
    e.typ  = randomType % 4;
    e.loc  = 11'(64 + int'(randomLocation) * 32);
    q.push_back(e);
  endtask

  task automatic do_rise(input logic [3:0] rt, input logic [3:0] rl,
                         input bit exp_spawn, input int slot);
    @(negedge clk);
    randomType     = rt;
    randomLocation = rl;
    generateNew    = 1'b1;
    if (exp_spawn) push_exp(slot);
    @(negedge clk);
    generateNew = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetN      = 1'b0;
    generateNew = 1'b0;
    enemyKilled = '0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({generateInstance, newSlot, newSlotOneHot, newType, newLocation,
         aliveMask, aliveCount, full, requestDropped} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got gi=%b s=%0d m=%h c=%0d f=%b d=%b, required all 0",
               generateInstance, newSlot, aliveMask, aliveCount, full,
               requestDropped);
    end
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_first_spawn();
    do_rise(4'd6, 4'd3, 1'b1, 0);
    #1;
    n_cmp++;
    if (generateInstance !== 1'b1 || newSlot !== 3'd0) begin
      n_bad++;
      $display("FAIL first_pulse: got gi=%b s=%0d, required gi=1 s=0",
               generateInstance, newSlot);
    end
    n_cmp++;
    if (newType !== 4'd2 || newLocation !== 11'd160) begin
      n_bad++;
      $display("FAIL first_type_loc: got t=%0d l=%0d, required t=2 l=160",
               newType, newLocation);
    end
    n_cmp++;
    if (aliveCount !== 4'd1 || aliveMask !== 8'h01) begin
      n_bad++;
      $display("FAIL first_alive: got c=%0d m=%h, required c=1 m=01",
               aliveCount, aliveMask);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (generateInstance !== 1'b0) begin
      n_bad++;
      $display("FAIL first_one_cycle: got gi=%b, required 0",
               generateInstance);
    end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      do_rise(4'($urandom_range(15)), 4'($urandom_range(15)), 1'b1, i);
      repeat (19) @(negedge clk);
    end
    #1;
    n_cmp++;
    if (q.size() != 0 || full !== 1'b1 || aliveCount !== 4'd8
        || aliveMask !== 8'hFF) begin
      n_bad++;
      $display("FAIL fill_full: got q=%0d f=%b c=%0d m=%h, required q=0 f=1 c=8 m=ff",
               q.size(), full, aliveCount, aliveMask);
    end
    do_rise(4'd1, 4'd1, 1'b0, 0);
    #1;
    n_cmp++;
    if (requestDropped !== 1'b0 || generateInstance !== 1'b0) begin
      n_bad++;
      $display("FAIL ninth_pending: got d=%b gi=%b, required d=0 gi=0",
               requestDropped, generateInstance);
    end
    repeat (19) @(negedge clk);
    do_rise(4'hB, 4'h9, 1'b0, 0);
    #1;
    n_cmp++;
    if (requestDropped !== 1'b1) begin
      n_bad++;
      $display("FAIL tenth_dropped: got %b, required 1", requestDropped);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (requestDropped !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_one_cycle: got %b, required 0", requestDropped);
    end
  endtask

  task automatic test_kill_full();
    @(negedge clk);
    enemyKilled = 8'h20;
    push_exp(5);
    @(negedge clk);
    enemyKilled = 8'h00;
    #1;
    n_cmp++;
    if (aliveMask !== 8'hDF || full !== 1'b0
        || generateInstance !== 1'b0) begin
      n_bad++;
      $display("FAIL kill_edge: got m=%h f=%b gi=%b, required m=df f=0 gi=0",
               aliveMask, full, generateInstance);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (generateInstance !== 1'b1 || newSlot !== 3'd5 || full !== 1'b1
        || aliveMask !== 8'hFF || q.size() != 0) begin
      n_bad++;
      $display("FAIL kill_respawn: got gi=%b s=%0d f=%b m=%h q=%0d, required gi=1 s=5 f=1 m=ff q=0",
               generateInstance, newSlot, full, aliveMask, q.size());
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_spacing();
    int first;
    int second;
    first  = -1;
    second = -1;
    apply_reset();
    @(negedge clk);
    randomType     = 4'd7;
    randomLocation = 4'd2;
    generateNew    = 1'b1;
    push_exp(0);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1 || i == 6) generateNew = 1'b0;
      if (i == 5) begin
        generateNew = 1'b1;
        push_exp(1);
      end
      #1;
      if (generateInstance) begin
        if (first < 0) first = i;
        else           second = i;
      end
    end
    n_cmp++;
    if (first != 1) begin
      n_bad++;
      $display("FAIL spawn_latency: got %0d, required 1", first);
    end
    n_cmp++;
    if (second - first != 17) begin
      n_bad++;
      $display("FAIL cooldown_spacing: got %0d, required 17",
               second - first);
    end
  endtask

  task automatic test_kill_collide();
    apply_reset();
    do_rise(4'd1, 4'd1, 1'b1, 0);
    repeat (20) @(negedge clk);
    @(negedge clk);
    generateNew = 1'b1;
    enemyKilled = 8'h01;
    push_exp(1);
    @(negedge clk);
    generateNew = 1'b0;
    enemyKilled = 8'h00;
    #1;
    n_cmp++;
    if (generateInstance !== 1'b1 || newSlot !== 3'd1
        || aliveMask !== 8'h02 || aliveCount !== 4'd1) begin
      n_bad++;
      $display("FAIL kill_collide: got gi=%b s=%0d m=%h c=%0d, required gi=1 s=1 m=02 c=1",
               generateInstance, newSlot, aliveMask, aliveCount);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    apply_reset();
    do_rise(4'd2, 4'd2, 1'b1, 0);
    repeat (3) @(negedge clk);
    do_rise(4'd3, 4'd3, 1'b0, 0);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    n_cmp++;
    if ({generateInstance, newSlot, newSlotOneHot, newType, newLocation,
         aliveMask, aliveCount, full, requestDropped} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_clear: got s=%0d t=%0d l=%0d m=%h c=%0d, required all 0",
               newSlot, newType, newLocation, aliveMask, aliveCount);
    end
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      #1;
      if (generateInstance) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL no_spawn_after_reset: got %0d pulses, required 0",
               pulses);
    end
    do_rise(4'd5, 4'd7, 1'b1, 0);
    #1;
    n_cmp++;
    if (generateInstance !== 1'b1 || aliveMask !== 8'h01) begin
      n_bad++;
      $display("FAIL fresh_rise: got gi=%b m=%h, required gi=1 m=01",
               generateInstance, aliveMask);
    end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_fill();
    test_kill_full();
    test_spacing();
    test_kill_collide();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/enemy_spawner.md
# enemy_spawner

Parametrised enemy spawner with slot management, the successor to the fixed-output enemy generator. It tracks which of `NUM_SLOTS` enemy instances are alive and allocates the lowest free slot on each rising edge of `generateNew`. Each spawn gets a type and a start location derived from the random inputs, and spawns are rate-limited by a cooldown. It sits between the random-number source and the per-slot enemy instances, and takes kill notifications back from the collision logic.

## Interface
- `NUM_SLOTS`, 8: number of enemy instances (2..32).
- `RAND_W`, 4: width of `randomType` and `randomLocation`.
- `NUM_TYPES`, 4: number of legal enemy types (1..2^RAND_W).
- `LOC_W`, 11: width of the location output.
- `LOC_MIN`, 64: X coordinate for `randomLocation` = 0.
- `LOC_STEP`, 32: X spacing per `randomLocation` step.
- `COOLDOWN`, 16: idle cycles enforced after each spawn (0 allowed).
- Derived: `SLOT_W` = $clog2(NUM_SLOTS); `CNT_W` = $clog2(NUM_SLOTS+1).

Ports:
- `clk`, in, 1: the single clock.
- `resetN`, in, 1: reset, asynchronous, active-low.
- `generateNew`, in, 1: spawn request; only its rising edge counts.
- `randomType`, in, RAND_W: random type seed.
- `randomLocation`, in, RAND_W: random location seed.
- `enemyKilled`, in, NUM_SLOTS: per-slot kill strobe; a set bit frees that slot.
- `generateInstance`, out, 1: one-cycle spawn pulse.
- `newSlot`, out, SLOT_W: slot id of the spawn.
- `newSlotOneHot`, out, NUM_SLOTS: one-hot form of `newSlot`, valid only while `generateInstance` = 1, otherwise 0.
- `newType`, out, RAND_W: randomType mod NUM_TYPES.
- `newLocation`, out, LOC_W: LOC_MIN + randomLocation*LOC_STEP, truncated to LOC_W.
- `aliveMask`, out, NUM_SLOTS: live slots.
- `aliveCount`, out, CNT_W: popcount of aliveMask.
- `full`, out, 1: all slots live.
- `requestDropped`, out, 1: one-cycle pulse when a request is discarded.

## Operation
- Edge detect: `rise = generateNew & ~genPrev`, where `genPrev` is a register.
- `pending` flag: holds at most one outstanding request.
- States:
  - IDLE: at a clock edge with (`rise` | `pending`) and `!full`, spawn.
    - Register the lowest free slot and the type and location computed from the inputs sampled at that edge.
    - Set `generateInstance`, set the slot's alive bit, clear `pending`.
    - Go to COOLDOWN with counter = COOLDOWN-1. If COOLDOWN = 0, stay in IDLE.
  - IDLE with `rise` while `full`: set `pending`.
  - COOLDOWN: decrement the counter; at 0 go to IDLE. A `rise` sets `pending`.
- Drop rule: a `rise` while `pending` = 1 and no spawn happens at that edge pulses `requestDropped`. `pending` stays set.
- Kill: at each edge, aliveMask &= ~enemyKilled. Kill bits on already-free slots are ignored.
- Kill and spawn at the same edge: free-slot selection uses the pre-kill mask. The freed slot becomes selectable next cycle.
- `aliveCount` and `full` are registered and consistent with `aliveMask` in the same cycle.

## Timing
- Reset values: all outputs 0, state IDLE, `pending` = 0, `genPrev` = 0. `genPrev` = 0 means a `generateNew` held high through reset counts as a rise at the first edge.
- Latency:
  - `generateNew` rising before edge k gives `generateInstance` high during cycle k..k+1, i.e. a 1-cycle latency.
  - `newSlot`, `newType` and `newLocation` are held until the next spawn.
- Minimum spacing between spawns: COOLDOWN+1 cycles.
- Full case: a freed slot spawns the pending request 1 cycle after the kill edge, provided IDLE.
- `resetN` asserted mid-cooldown or while pending: all state is cleared immediately, with no spawn after release until a new rise.

## Structure
- Package `enemy_pkg`:
  - state enum {IDLE, COOLDOWN};
  - default NUM_TYPES, LOC_MIN, LOC_STEP, LOC_W;
  - a `loc_t` typedef.
- Sub-module `lowest_free_finder`: parametrised priority encoder, ~aliveMask → {found, index, onehot}.

## Test plan
- Reset, then a rise with randomType = 6, randomLocation = 3 (NUM_TYPES = 4) → 1 cycle later: pulse, slot 0, type 2, location 160, aliveCount 1.
- Eight rises spaced 20 cycles apart → slots 0..7 in order, full = 1. Ninth rise → pending; tenth rise → requestDropped pulse.
- From the full state, enemyKilled = 8'h20 → pending spawn into slot 5 one cycle after the kill, full = 1.
- Two rises 5 cycles apart, COOLDOWN = 16 → second spawn exactly 17 cycles after the first.
- Kill slot 0 at the same edge as a spawn with mask 8'h01 → spawn goes to slot 1, mask becomes 8'h02.
- Reset pulse during cooldown with pending set → outputs 0, no spawn until a fresh rise.
